// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V decode definitions (opcodes, immediate formats,
//               control bundle) for the decode/operand-fetch slice.
// Revision    : 1.0
// ============================================================================
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_OPIMM  = 7'b001_0011;
    localparam logic [6:0] OP_OP     = 7'b011_0011;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic jump;
    } ctrl_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_JALR: imm_type_of = IMM_I;
            OP_STORE:                   imm_type_of = IMM_S;
            OP_BRANCH:                  imm_type_of = IMM_B;
            OP_LUI, OP_AUIPC:           imm_type_of = IMM_U;
            OP_JAL:                     imm_type_of = IMM_J;
            default:                    imm_type_of = IMM_NONE;
        endcase
    endfunction

    // Unknown opcodes fall through with every control bit low (NOP).
    function automatic ctrl_t ctrl_of(input logic [6:0] opcode);
        ctrl_of = '0;
        case (opcode)
            OP_LOAD: begin
                ctrl_of.regwrite = 1'b1;
                ctrl_of.memread  = 1'b1;
            end
            OP_STORE:  ctrl_of.memwrite = 1'b1;
            OP_BRANCH: ctrl_of.branch   = 1'b1;
            OP_JAL, OP_JALR: begin
                ctrl_of.regwrite = 1'b1;
                ctrl_of.jump     = 1'b1;
            end
            OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC: ctrl_of.regwrite = 1'b1;
            default: ctrl_of = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RISC-V immediate generator (I/S/B/U/J formats,
//               sign-extended from instruction bit 31).
// Revision    : 1.0
// ============================================================================
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    import riscv_pkg::*;

    imm_type_e w_type;

    assign w_type = imm_type_of(instr[6:0]);

    always_comb begin
        imm = '0;
        case (w_type)
            IMM_I:   imm = XLEN'($signed(instr[31:20]));
            IMM_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_operand_stage
// Description : Decode / operand-fetch stage with writeback bypass, load-use
//               bubble and a valid/ready ID/EX register with flush.
//               Optional macro DECODE_BRANCH_TARGET_EN adds the pc+imm
//               branch-target adder.
// Revision    : 1.0
// ============================================================================
module decode_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    input  logic              flush,
    output logic [REG_AW-1:0] rf_read_reg_num1,
    output logic [REG_AW-1:0] rf_read_reg_num2,
    input  logic [XLEN-1:0]   rf_read_data1,
    input  logic [XLEN-1:0]   rf_read_data2,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [XLEN-1:0]   wb_write_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [6:0]        ex_opcode,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [XLEN-1:0]   ex_branch_target
);
    import riscv_pkg::*;

    logic [6:0]        w_opcode;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    ctrl_t             w_ctrl;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_hazard;
    logic              w_stall;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_val;
    logic [XLEN-1:0]   r_rs2_val;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [6:0]        r_opcode;
    logic [2:0]        r_funct3;
    logic              r_funct7b5;
    ctrl_t             r_ctrl;

    assign w_opcode = if_instr[6:0];
    assign w_rd     = if_instr[11:7];
    assign w_rs1    = if_instr[19:15];
    assign w_rs2    = if_instr[24:20];
    assign w_ctrl   = ctrl_of(w_opcode);

    assign rf_read_reg_num1 = w_rs1;
    assign rf_read_reg_num2 = w_rs2;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (if_instr[31:0]),
        .imm   (w_imm)
    );

    // Same-cycle writeback wins over the register file so a write is never missed.
    always_comb begin
        w_rs1_val = rf_read_data1;
        if (w_rs1 == '0)
            w_rs1_val = '0;
        else if (wb_regwrite && (wb_write_reg == w_rs1))
            w_rs1_val = wb_write_data;
    end

    always_comb begin
        w_rs2_val = rf_read_data2;
        if (w_rs2 == '0)
            w_rs2_val = '0;
        else if (wb_regwrite && (wb_write_reg == w_rs2))
            w_rs2_val = wb_write_data;
    end

    assign w_use_rs1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
    assign w_use_rs2 = (w_opcode == OP_OP) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);

    assign w_hazard = r_valid && r_ctrl.memread && (r_rd != '0) &&
                      ((w_use_rs1 && (r_rd == w_rs1)) || (w_use_rs2 && (r_rd == w_rs2)));
    assign w_stall  = r_valid && !ex_ready;
    assign id_ready = !flush && (!r_valid || ex_ready) && !(if_valid && w_hazard);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_val  <= '0;
            r_rs2_val  <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_ctrl     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_stall) begin
            r_valid <= r_valid;
        end else if (if_valid && w_hazard) begin
            r_valid <= 1'b0;
        end else if (if_valid) begin
            r_valid    <= 1'b1;
            r_pc       <= if_pc;
            r_rs1_val  <= w_rs1_val;
            r_rs2_val  <= w_rs2_val;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_opcode   <= w_opcode;
            r_funct3   <= if_instr[14:12];
            r_funct7b5 <= if_instr[30];
            r_ctrl     <= w_ctrl;
        end else begin
            r_valid <= 1'b0;
        end
    end

`ifdef DECODE_BRANCH_TARGET_EN
    logic [XLEN-1:0] w_branch_target;
    logic [XLEN-1:0] r_branch_target;

    assign w_branch_target = (w_ctrl.branch || (w_opcode == OP_JAL)) ? (if_pc + w_imm) : '0;

    always_ff @(posedge clock) begin
        if (reset)
            r_branch_target <= '0;
        else if (if_valid && id_ready)
            r_branch_target <= w_branch_target;
    end

    assign ex_branch_target = r_branch_target;
`else
    assign ex_branch_target = '0;
`endif

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_rs1_val  = r_rs1_val;
    assign ex_rs2_val  = r_rs2_val;
    assign ex_imm      = r_imm;
    assign ex_rd       = r_rd;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_opcode   = r_opcode;
    assign ex_funct3   = r_funct3;
    assign ex_funct7b5 = r_funct7b5;
    assign ex_regwrite = r_ctrl.regwrite;
    assign ex_memread  = r_ctrl.memread;
    assign ex_memwrite = r_ctrl.memwrite;
    assign ex_branch   = r_ctrl.branch;
    assign ex_jump     = r_ctrl.jump;

endmodule
`default_nettype wire

// File: tb/tb_decode_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_operand_stage
// Description : Scoreboard bench for decode_operand_stage: directed cases
//               followed by randomized traffic against a reference model.
// Revision    : 1.0
// ============================================================================
module tb_decode_operand_stage;
    import riscv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic [4:0]  rf_read_reg_num1;
    logic [4:0]  rf_read_reg_num2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        wb_regwrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_branch_target;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump;

    always #5 clock = ~clock;

    decode_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush),
        .rf_read_reg_num1(rf_read_reg_num1), .rf_read_reg_num2(rf_read_reg_num2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_branch_target(ex_branch_target)
    );

    // Register file: x0 holds junk so the stage itself must force zero.
    logic [31:0] rf_mem [32];
    assign rf_read_data1 = rf_mem[rf_read_reg_num1];
    assign rf_read_data2 = rf_mem[rf_read_reg_num2];

    typedef struct {
        logic [31:0] pc, rs1v, rs2v, imm, tgt;
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, rw, mr, mw, br, jp, immk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] r, input logic wbw,
                                         input logic [4:0] wbr, input logic [31:0] wbd);
        if (r == 5'd0) return 32'd0;
        if (wbw && wbr == r) return wbd;
        return rf_mem[r];
    endfunction

    function automatic bit uses1(input logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {OP_OP, OP_STORE, OP_BRANCH};
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic wbw,
                                   input logic [4:0] wbr, input logic [31:0] wbd);
        exp_t e;
        logic [6:0] op;
        op     = ins[6:0];
        e.pc   = pc;   e.op  = op;
        e.rd   = ins[11:7];  e.rs1 = ins[19:15];  e.rs2 = ins[24:20];
        e.f3   = ins[14:12]; e.f7  = ins[30];
        e.rs1v = opnd(e.rs1, wbw, wbr, wbd);
        e.rs2v = opnd(e.rs2, wbw, wbr, wbd);
        e.rw   = op inside {OP_LOAD, OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
        e.mr   = (op == OP_LOAD);
        e.mw   = (op == OP_STORE);
        e.br   = (op == OP_BRANCH);
        e.jp   = op inside {OP_JAL, OP_JALR};
        e.immk = 1'b1;
        case (op)
            OP_LOAD, OP_OPIMM, OP_JALR: e.imm = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:                   e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:                  e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:           e.imm = {ins[31:12], 12'd0};
            OP_JAL:                     e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: begin e.imm = 32'd0; e.immk = 1'b0; end
        endcase
`ifdef DECODE_BRANCH_TARGET_EN
        e.tgt = (op == OP_BRANCH || op == OP_JAL) ? pc + e.imm : 32'd0;
`else
        e.tgt = 32'd0;
`endif
        return e;
    endfunction

    // One cycle of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic rs, input logic wbw, input logic [4:0] wbr,
                        input logic [31:0] wbd, output logic rdy_obs, output logic acc);
        exp_t e;
        logic mv, hz, er;
        if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl; reset = rs;
        wb_regwrite = wbw; wb_write_reg = wbr; wb_write_data = wbd;
        e  = model(ins, pc, wbw, wbr, wbd);
        mv = (q.size() != 0);
        hz = mv && q[0].mr && (q[0].rd != 5'd0) &&
             ((uses1(ins[6:0]) && q[0].rd == e.rs1) || (uses2(ins[6:0]) && q[0].rd == e.rs2));
        er  = !fl && (!mv || rdy) && !(v && hz);
        acc = v && er && !rs;
        #2;
        rdy_obs = id_ready;
        chk("rf_read_reg_num1", 32'(rf_read_reg_num1), 32'(e.rs1));
        chk("rf_read_reg_num2", 32'(rf_read_reg_num2), 32'(e.rs2));
        if (!rs) chk("id_ready", 32'(id_ready), 32'(er));
        @(posedge clock);
        #1;
        if (rs) q.delete();
        else if (acc) q.push_back(e);
        if (wbw && wbr != 5'd0) rf_mem[wbr] = wbd;
    endtask

    // Monitor: the ID/EX contents must always equal the scoreboard head.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            chk("ex_valid", 32'(ex_valid), 32'(q.size() != 0));
            if (ex_valid && q.size() != 0) begin
                chk("ex_pc", ex_pc, q[0].pc);
                chk("ex_rs1_val", ex_rs1_val, q[0].rs1v);
                chk("ex_rs2_val", ex_rs2_val, q[0].rs2v);
                chk("ex_regnums", 32'({ex_rd, ex_rs1, ex_rs2}), 32'({q[0].rd, q[0].rs1, q[0].rs2}));
                chk("ex_opfields", 32'({ex_opcode, ex_funct3, ex_funct7b5}), 32'({q[0].op, q[0].f3, q[0].f7}));
                chk("ex_ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump}),
                    32'({q[0].rw, q[0].mr, q[0].mw, q[0].br, q[0].jp}));
                if (q[0].immk) chk("ex_imm", ex_imm, q[0].imm);
                chk("ex_branch_target", ex_branch_target, q[0].tgt);
                if (ex_ready || flush) void'(q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 9))
            0: ins[6:0] = OP_LOAD;   1: ins[6:0] = OP_STORE;  2: ins[6:0] = OP_BRANCH;
            3: ins[6:0] = OP_JAL;    4: ins[6:0] = OP_JALR;   5: ins[6:0] = OP_OPIMM;
            6: ins[6:0] = OP_OP;     7: ins[6:0] = OP_LUI;    8: ins[6:0] = OP_AUIPC;
            default: ins[6:0] = 7'b111_1111;
        endcase
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        logic r, a, v, rdy, fl, wbw, held;
        logic [31:0] ins, pc;
        logic [31:0] tgt_beq;
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'hBAD0_0BAD;
        reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        ex_ready = 1'b1; wb_regwrite = 1'b0; wb_write_reg = '0; wb_write_data = '0;
        @(posedge clock); #1;
        step(0, 32'h0, 32'h0, 1, 0, 1, 0, 5'd0, 32'h0, r, a);
        step(0, 32'h0, 32'h0, 1, 0, 1, 0, 5'd0, 32'h0, r, a);

        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_ex_pc", ex_pc, 32'd0);
        chk("reset_ex_imm", ex_imm, 32'd0);
        chk("reset_ex_rs1_val", ex_rs1_val, 32'd0);
        chk("reset_ex_ctrl", 32'({ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump}), 32'd0);
        mon_en = 1'b1;

        // ADDI x5,x0,7 at 0x100
        step(1, 32'h0070_0293, 32'h100, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        chk("addi_id_ready", 32'(r), 32'd1);
        chk("addi_ex_valid", 32'(ex_valid), 32'd1);
        chk("addi_ex_rd", 32'(ex_rd), 32'd5);
        chk("addi_ex_imm", ex_imm, 32'd7);
        chk("addi_ex_rs1_val", ex_rs1_val, 32'd0);
        chk("addi_ex_regwrite", 32'(ex_regwrite), 32'd1);

        // ADD x4,x3,x3 while writeback updates x3
        rf_mem[3] = 32'd3;
        step(1, 32'h0031_8233, 32'h104, 1, 0, 0, 1, 5'd3, 32'hDEAD, r, a);
        chk("bypass_rs1", ex_rs1_val, 32'hDEAD);
        chk("bypass_rs2", ex_rs2_val, 32'hDEAD);

        // LW x6,0(x1); ADD x7,x6,x2 -> one bubble
        step(1, 32'h0000_A303, 32'h108, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        step(1, 32'h0023_03B3, 32'h10C, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        chk("loaduse_bubble_id_ready", 32'(r), 32'd0);
        chk("loaduse_bubble_ex_valid", 32'(ex_valid), 32'd0);
        step(1, 32'h0023_03B3, 32'h10C, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        chk("loaduse_accept_id_ready", 32'(r), 32'd1);
        chk("loaduse_accept_pc", ex_pc, 32'h10C);
        // LW x6 then LUI x6 -> no bubble
        step(1, 32'h0000_A303, 32'h110, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        step(1, 32'h1234_5337, 32'h114, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        chk("lw_lui_no_bubble", 32'(r), 32'd1);

        // Backpressure for three cycles, then release
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0010_0093, 32'h118, 0, 0, 0, 0, 5'd0, 32'h0, r, a);
            chk("stall_id_ready", 32'(r), 32'd0);
            chk("stall_ex_pc", ex_pc, 32'h114);
        end
        step(1, 32'h0010_0093, 32'h118, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        chk("stall_release_pc", ex_pc, 32'h118);

        // Flush while stalled
        step(1, 32'h0020_0113, 32'h11C, 0, 1, 0, 0, 5'd0, 32'h0, r, a);
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);

        // BEQ x0,x0,-8 at pc 4
        step(1, 32'hFE00_0CE3, 32'h4, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
`ifdef DECODE_BRANCH_TARGET_EN
        tgt_beq = 32'hFFFF_FFFC;
`else
        tgt_beq = 32'h0;
`endif
        chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
        chk("beq_branch_target", ex_branch_target, tgt_beq);

        // Reset while stalled
        step(1, 32'h0030_0193, 32'h120, 0, 0, 0, 0, 5'd0, 32'h0, r, a);
        step(1, 32'h0040_0213, 32'h124, 0, 0, 1, 0, 5'd0, 32'h0, r, a);
        chk("rst_stall_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_stall_ex_pc", ex_pc, 32'd0);
        chk("rst_stall_ex_imm", ex_imm, 32'd0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        chk("post_reset_id_ready", 32'(r), 32'd1);

        // Randomized traffic; fetch holds an instruction until it is accepted
        held = 1'b0; ins = '0; pc = '0;
        for (int n = 0; n < 800; n++) begin
            v = ($urandom_range(0, 9) < 8);
            if (!held) begin
                ins = rand_instr();
                pc  = $urandom & 32'hFFFF_FFFC;
            end
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            wbw = $urandom_range(0, 1) == 1;
            step(v, ins, pc, rdy, fl, 0, wbw, 5'($urandom_range(0, 7)), $urandom, r, a);
            held = v && !a;
        end

        for (int i = 0; i < 3; i++)
            step(0, 32'h0, 32'h0, 1, 0, 0, 0, 5'd0, 32'h0, r, a);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        chk("drain_ex_valid", 32'(ex_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_operand_stage.md
# decode_operand_stage

Instruction-decode / operand-fetch stage of the RISC-V pipeline, sitting directly upstream of the execute stage and alongside the 32x32 register file. It decodes the fetched instruction and drives the register-file read addresses. It applies a writeback-to-decode bypass, inserts a one-cycle bubble on load-use hazards, and holds the ID/EX pipeline register behind a valid/ready handshake, with flush on branch mispredict.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register-number width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch offers instruction
- if_instr  in  XLEN  instruction word
- if_pc  in  XLEN  its PC
- id_ready  out  1  stage accepts instruction this cycle
- flush  in  1  mispredict; kill ID and ID/EX contents
- rf_read_reg_num1 / rf_read_reg_num2  out  REG_AW  register-file read addresses (= rs1, rs2)
- rf_read_data1 / rf_read_data2  in  XLEN  register-file read data (combinational)
- wb_regwrite, wb_write_reg, wb_write_data  in  1/REG_AW/XLEN  writeback port (same signals drive the register file)
- ex_ready  in  1  execute accepts ID/EX contents
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN  registered operands
- ex_rd, ex_rs1, ex_rs2  out  REG_AW  registered register numbers
- ex_opcode  out  7;  ex_funct3  out  3;  ex_funct7b5  out  1
- ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump  out  1  decoded controls
- ex_branch_target  out  XLEN  (see Configuration)

## Operation
- Decode fields: rs1=[19:15], rs2=[24:20], rd=[11:7]. Read addresses are driven combinationally from if_instr, regardless of if_valid.
- Immediate formats I/S/B/U/J, sign-extended from bit 31. B and J immediates have bit 0 = 0.
- Operand select per source, in priority order:
  - rs==0 → 0.
  - wb_regwrite && wb_write_reg==rs && rs!=0 → wb_write_data (bypass).
  - Otherwise the register-file data.
- use_rs1: all opcodes except LUI, AUIPC, JAL. use_rs2: R-type, STORE, BRANCH.
- Load-use hazard = ex_valid && ex_memread && ex_rd!=0 && ((use_rs1 && ex_rd==rs1) || (use_rs2 && ex_rd==rs2)).
- id_ready = !flush && (!ex_valid || ex_ready) && !(if_valid && hazard).
- ID/EX register update at each posedge, in priority order:
  - reset → all outputs 0.
  - flush → ex_valid=0 only.
  - ex_valid && !ex_ready → hold all fields.
  - if_valid && hazard → ex_valid=0 (bubble); the instruction stays at fetch.
  - if_valid && id_ready → capture all fields, ex_valid=1.
  - Otherwise → ex_valid=0.
- Unrecognised opcodes are captured with all control bits 0 (NOP behaviour).

## Timing
- Latency: one cycle from accept (if_valid && id_ready at edge N) to ex_valid at N+1.
- Throughput: one instruction per cycle with no hazards.
- Load-use costs exactly one bubble. The cycle after the bubble the load has left ID/EX, so the hazard clears and the instruction is accepted.
- Register file and bypass are combinational into the ID/EX capture. A write in the same cycle is seen via bypass, never as stale data.
- Stall: ID/EX fields are stable while ex_valid && !ex_ready.
- Flush with ex_valid && !ex_ready still clears ex_valid. Flush overrides hazard and accept.
- reset mid-stall: next cycle ex_valid=0 and all outputs 0. id_ready=1 once reset deasserts.

## Configuration
- DECODE_BRANCH_TARGET_EN defined:
  - ex_branch_target = if_pc + imm (XLEN-bit, wrap-around modulo 2^XLEN), captured for B-type and JAL.
  - For all other instructions, captured as 0.
- Undefined: ex_branch_target is tied to 0 and the adder is absent; execute computes the target.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC);
  - the imm_type enum;
  - XLEN / REG_AW defaults.
- One sub-module, imm_gen: a combinational immediate generator (instr → imm). All sequential logic lives in the top module.

## Test plan
- ADDI x5,x0,7 (0x00700293) at pc 0x100, ex_ready=1 → next cycle:
  - ex_valid=1, ex_rd=5, ex_imm=7, ex_rs1_val=0, ex_regwrite=1.
- Bypass: register x3 holds 3; wb writes x3=0xDEAD in the same cycle ADD x4,x3,x3 is accepted → ex_rs1_val=ex_rs2_val=0xDEAD.
- Load-use: LW x6,0(x1) followed by ADD x7,x6,x2:
  - one bubble cycle with id_ready=0;
  - ADD accepted the following cycle;
  - LW followed by LUI x6 has no bubble.
- Backpressure: ex_ready=0 for 3 cycles → ID/EX fields unchanged, id_ready=0; no instruction lost or duplicated.
- Flush while stalled → ex_valid=0 next cycle; the offered instruction is not captured.
- With DECODE_BRANCH_TARGET_EN: BEQ imm=-8 at pc 0x4 → ex_branch_target=0xFFFFFFFC. Without the macro → 0.
